// File: rtl/ram_rd_check_if.sv
// ram_rd_check_if
//   Bundles the read-sweep checker's start/status handshake and its RAM read
//   port into one interface.
//
//   Signals:
//     start          1       pulse that begins a sweep when the checker is idle
//     ram_rd_en      1       RAM read enable
//     ram_rd_addr    ADDR_W  RAM read address
//     ram_rd_data    DATA_W  RAM read data, RD_LAT clocks after the request
//     busy           1       sweep in progress
//     done           1       one-cycle pulse at sweep end
//     err_flag       1       sticky mismatch flag for the current/last sweep
//     err_cnt        8       saturating mismatch count
//     first_err_addr ADDR_W  (ERR_CAPTURE_EN only) address of first mismatch
//     first_err_data DATA_W  (ERR_CAPTURE_EN only) data of first mismatch
//
//   Modports:
//     master  the checker (drives the RAM read request and status)
//     slave   the environment (drives start and the RAM read data)
//
//   Optional feature macro: ERR_CAPTURE_EN
interface ram_rd_check_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              start;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              busy;
    logic              done;
    logic              err_flag;
    logic [7:0]        err_cnt;
`ifdef ERR_CAPTURE_EN
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;

    modport master (
        input  start, ram_rd_data,
        output ram_rd_en, ram_rd_addr, busy, done, err_flag, err_cnt,
        output first_err_addr, first_err_data
    );
    modport slave (
        output start, ram_rd_data,
        input  ram_rd_en, ram_rd_addr, busy, done, err_flag, err_cnt,
        input  first_err_addr, first_err_data
    );
`else
    modport master (
        input  start, ram_rd_data,
        output ram_rd_en, ram_rd_addr, busy, done, err_flag, err_cnt
    );
    modport slave (
        output start, ram_rd_data,
        input  ram_rd_en, ram_rd_addr, busy, done, err_flag, err_cnt
    );
`endif
endinterface

// File: rtl/ram_rd_check.sv
// ram_rd_check
//   Read-side checker for the 2-port RAM. A start pulse sweeps every address
//   0..DEPTH-1 on the read port (one per clock), lines the returned data up
//   with the RAM read latency and compares word k against k + DATA_OFS
//   (modulo 2^DATA_W). Reports a done pulse, a sticky error flag and a
//   saturating mismatch count.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   ram_rd_check_if.master: start, ram_rd_en, ram_rd_addr,
//           ram_rd_data, busy, done, err_flag, err_cnt
//           (+ first_err_addr, first_err_data with ERR_CAPTURE_EN)
//
//   Optional feature macro: ERR_CAPTURE_EN -- latches the address and data of
//   the first mismatch in each sweep.
//
//   Timing: start sampled on edge E0 issues addresses 0..DEPTH-1 in the cycles
//   after E0..E(DEPTH-1); done is high in the cycle after E(DEPTH+RD_LAT), by
//   which time the last word has been compared.
module ram_rd_check #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int RD_LAT   = 1,
    parameter int DATA_OFS = 0
) (
    input  logic           clk,
    input  logic           rst,
    ram_rd_check_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    localparam int                LAT_W     = 2;
    // Explicit terminal address so DEPTH = 2^ADDR_W never depends on wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic              err_flag;
    logic [7:0]        err_cnt;

    // Latency pipe: valid is control (reset), the address rides along as data.
    logic [RD_LAT-1:0] vld_p;
    logic [ADDR_W-1:0] addr_p [RD_LAT];

    logic              mismatch;

`ifdef ERR_CAPTURE_EN
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;
`endif

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) + 32'(DATA_OFS));
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign mismatch = vld_p[RD_LAT-1] &&
                      (bus.ram_rd_data != exp_word(addr_p[RD_LAT-1]));

    // Stage: address pipe, aligned with the RAM read latency
    always_ff @(posedge clk) begin
        addr_p[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_p[i] <= addr_p[i-1];
        end
    end

    // Stage: sweep FSM, valid pipe and compare result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
            vld_p    <= '0;
`ifdef ERR_CAPTURE_EN
            first_err_addr <= '0;
            first_err_data <= '0;
`endif
        end else begin
            vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            if (mismatch) begin
                err_flag <= 1'b1;
                err_cnt  <= sat_inc(err_cnt);
`ifdef ERR_CAPTURE_EN
                // err_flag is still clear only for the first mismatch of a sweep
                if (!err_flag) begin
                    first_err_addr <= addr_p[RD_LAT-1];
                    first_err_data <= bus.ram_rd_data;
                end
`endif
            end

            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= READ;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        vld_p    <= '0;
                        err_flag <= 1'b0;
                        err_cnt  <= '0;
`ifdef ERR_CAPTURE_EN
                        first_err_addr <= '0;
                        first_err_data <= '0;
`endif
                    end
                end
                READ: begin
                    if (rd_addr == LAST_ADDR) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        lat_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Wait until the last request has left the latency pipe.
                    if (lat_cnt == LAT_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_addr;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err_flag    = err_flag;
    assign bus.err_cnt     = err_cnt;
`ifdef ERR_CAPTURE_EN
    assign bus.first_err_addr = first_err_addr;
    assign bus.first_err_data = first_err_data;
`endif

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
Read-side stage that sits directly downstream of the RAM write stage on the 2-port RAM. On a start pulse it sweeps every RAM address in ascending order on the read port. It aligns the returned data to the RAM read latency and compares each word against the expected pattern written upstream (word k = k + DATA_OFS). It reports done, a sticky error flag and a saturating mismatch count for LED/debug use.

Parameters:
ADDR_W, 5, read address width
DATA_W, 8, RAM data width
DEPTH, 32, number of words swept (2..2^ADDR_W)
RD_LAT, 1, RAM read latency in clocks (1..3)
DATA_OFS, 0, expected data = address + DATA_OFS, modulo 2^DATA_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep when idle
ram_rd_en  output  1  RAM read enable
ram_rd_addr  output  ADDR_W  RAM read address
ram_rd_data  input  DATA_W  RAM read data, valid RD_LAT clocks after ram_rd_en/addr
busy  output  1  high from the cycle after start accepted until done
done  output  1  one-cycle pulse at sweep end
err_flag  output  1  sticky; set on any mismatch in the current/last sweep
err_cnt  output  8  mismatch count, saturates at 255

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, any time, including mid-sweep):
  - FSM goes to IDLE.
  - ram_rd_en=0, ram_rd_addr=0, busy=0, done=0, err_flag=0, err_cnt=0.
  - Latency pipe is cleared. Nothing is pending after reset is released.
- FSM states IDLE, READ, DRAIN, FIN:
  - IDLE: start=1 -> READ. Clears err_flag, err_cnt and the latency pipe in the same edge.
  - READ: ram_rd_en=1 with addr 0,1,…,DEPTH-1, one per clock, all registered. When the issued addr is DEPTH-1 -> DRAIN. Addr returns to 0 and ram_rd_en=0 from the next cycle.
  - DRAIN: hold for RD_LAT clocks so the last word is compared -> FIN.
  - FIN: done=1 for exactly one cycle, busy=0 from that edge -> IDLE.
- busy=1 throughout READ and DRAIN.
- start while busy or in FIN is ignored, with no restart and no counter change.
- Compare pipeline:
  - The valid bit and address are shifted through an RD_LAT-deep register pipe alongside the RAM.
  - On a pipe-output valid, compare ram_rd_data against (addr + DATA_OFS) truncated to DATA_W.
  - On mismatch: err_flag<=1; err_cnt<=err_cnt+1 unless already 255.
- Cycle count: a sweep is exactly DEPTH + RD_LAT + 1 clocks from the start edge to the done pulse inclusive. Default: 34 clocks.
- Address arithmetic: DEPTH = 2^ADDR_W wraps naturally. The terminal compare must use DEPTH-1 and must not rely on overflow.
- err_flag/err_cnt hold their values after done until the next accepted start or reset.

Optional Feature:
ERR_CAPTURE_EN
- When defined, two extra outputs are added:
  - first_err_addr (ADDR_W) and first_err_data (DATA_W).
  - They latch the address and received data of the first mismatch of a sweep.
  - Both clear to 0 on reset and on an accepted start, and hold until then.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- RAM preloaded k->k, RD_LAT=1, one start pulse -> addr 0..31 on 32 consecutive cycles with ram_rd_en=1; done on cycle 34; err_flag=0, err_cnt=0.
- Corrupt word 5 (0x05->0xA5) and word 31 -> err_flag=1, err_cnt=2. With ERR_CAPTURE_EN: first_err_addr=5, first_err_data=0xA5.
- start pulsed again at cycle 10 of a sweep -> ignored; addr sequence uninterrupted; exactly one done.
- rst asserted at sweep cycle 12 for one clock -> all outputs 0 immediately. A fresh start then gives a clean 34-cycle sweep with err_cnt=0.
- RD_LAT=3, DATA_OFS=8'h10, RAM preloaded k->k+0x10 -> no errors; done 36 cycles after start; the last compare uses addr 31 data 0x2F.
- RAM all 0xFF with DEPTH=32, sweep run 9 times without restart clearing inspected each time -> err_cnt=32 per sweep. A forced DEPTH=256/ADDR_W=8 sweep of all-bad data -> err_cnt saturates at 255.
